// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Shared definitions for the HDB3 transmit/receive control logic.
//   SYM_*             2-bit encoder symbol codes (V and B are produced
//                     downstream only, never by the transmit sequencer)
//   HDB3_DELAY_DEPTH  depth of the encoder's V/B look-ahead delay line
//   hdb3_tx_state_t   transmit sequencer states
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_V    = 2'b10;
    localparam logic [1:0] SYM_B    = 2'b11;

    localparam int HDB3_DELAY_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FLUSH = 2'd3
    } hdb3_tx_state_t;

endpackage

// File: rtl/hdb3_bit_timer.sv
// hdb3_bit_timer
// Bit-period timer: counts 0..div and wraps; tick is high on the terminal
// count. div = 0 ticks every cycle. Shared with the receive side.
//   clk    system clock
//   reset  synchronous, active-high reset
//   clear  holds the count at 0 (restart of the bit period)
//   div    bit period minus 1, in clk cycles
//   tick   high for one cycle at the end of each bit period
module hdb3_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = (count == div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hdb3_tx_ctrl.sv
// hdb3_tx_ctrl
// Transmit sequencer in front of the HDB3 encoder chain. Takes host bytes
// over valid/ready, serialises them into encoder symbols at a programmable
// bit rate, clears the encoder state at frame start and flushes its delay
// line at frame end.
//   clk, reset        system clock, synchronous active-high reset
//   cfg_div           bit period minus 1; latched when a frame starts
//   s_valid/s_ready   host byte handshake; s_data byte, s_last end of frame
//   enc_ce/enc_data   one pulse + symbol per transmitted bit
//   enc_clr           one-cycle encoder state clear at frame start
//   busy              high whenever not idle
//   frame_done        pulse after the flush bits have gone out
//   underrun          pulse on every fill bit inserted between bytes
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for the first byte of a frame
// ST_CLEAR | one cycle: encoder cleared, bit timer restarted
// ST_SHIFT | sending data bits (or fill bits when the host is late)
// ST_FLUSH | sending FLUSH_BITS zeros, then frame_done
module hdb3_tx_ctrl
    import hdb3_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FLUSH_BITS = HDB3_DELAY_DEPTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             enc_ce,
    output logic [1:0]       enc_data,
    output logic             enc_clr,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int FC_W = (FLUSH_BITS < 1) ? 1 : $clog2(FLUSH_BITS + 1);

    hdb3_tx_state_t   state;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       cur_data;
    logic [7:0]       nxt_data;
    logic             cur_last;
    logic             nxt_last;
    logic             nxt_valid;
    logic             filling;
    logic [2:0]       idx;
    logic [FC_W-1:0]  flush_cnt;
    logic             tick;
    logic             accept;
    logic             cur_bit;
    logic             slot_end;
    logic             timer_clear;

    assign s_ready = (state == ST_IDLE) ||
                     ((state == ST_SHIFT) && !nxt_valid && !cur_last);
    assign accept  = s_valid && s_ready;

    assign cur_bit = MSB_FIRST ? cur_data[~idx] : cur_data[idx];

    // A slot is either one whole byte or one fill bit, so a byte boundary
    // is reached after bit index 7 or after every fill bit.
    assign slot_end = filling || (idx == 3'd7);

    assign timer_clear = (state == ST_IDLE) || (state == ST_CLEAR);

    hdb3_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_q      <= '0;
            cur_data   <= '0;
            nxt_data   <= '0;
            cur_last   <= 1'b0;
            nxt_last   <= 1'b0;
            nxt_valid  <= 1'b0;
            filling    <= 1'b0;
            idx        <= '0;
            flush_cnt  <= '0;
            enc_ce     <= 1'b0;
            enc_data   <= SYM_ZERO;
            enc_clr    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            enc_ce     <= 1'b0;
            enc_data   <= SYM_ZERO;
            enc_clr    <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_data  <= s_data;
                        cur_last  <= s_last;
                        div_q     <= cfg_div;
                        idx       <= '0;
                        filling   <= 1'b0;
                        nxt_valid <= 1'b0;
                        enc_clr   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    state <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    // A byte accepted on a slot-ending tick bypasses the
                    // next-byte buffer and goes straight to the shifter.
                    if (accept && !(tick && slot_end)) begin
                        nxt_data  <= s_data;
                        nxt_last  <= s_last;
                        nxt_valid <= 1'b1;
                    end
                    if (tick) begin
                        enc_ce   <= 1'b1;
                        underrun <= filling;
                        enc_data <= (!filling && cur_bit) ? SYM_ONE : SYM_ZERO;
                        idx      <= idx + 3'd1;
                        if (slot_end) begin
                            idx <= '0;
                            if (!filling && cur_last) begin
                                flush_cnt <= FC_W'(FLUSH_BITS);
                                state     <= ST_FLUSH;
                            end else if (nxt_valid) begin
                                cur_data  <= nxt_data;
                                cur_last  <= nxt_last;
                                nxt_valid <= 1'b0;
                                filling   <= 1'b0;
                            end else if (accept) begin
                                cur_data <= s_data;
                                cur_last <= s_last;
                                filling  <= 1'b0;
                            end else begin
                                filling <= 1'b1;
                            end
                        end
                    end
                end

                ST_FLUSH: begin
                    // The count reaching zero is handled one cycle after the
                    // last flush tick, which places frame_done after it.
                    if (flush_cnt == '0) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (tick) begin
                        enc_ce    <= 1'b1;
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// tb_hdb3_tx_ctrl
// Scoreboard bench for hdb3_tx_ctrl: each frame's expected event stream
// (enc_clr, symbols with spacing, frame_done) is queued before the bytes
// are driven; a monitor on the falling edge pops and compares.
module tb_hdb3_tx_ctrl;
    import hdb3_pkg::*;

    localparam int DIV_W  = 16;
    localparam int K_CLR  = 0;
    localparam int K_SYM  = 1;
    localparam int K_DONE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] cfg_div;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             enc_ce;
    logic [1:0]       enc_data;
    logic             enc_clr;
    logic             busy;
    logic             frame_done;
    logic             underrun;

    always #5 clk = ~clk;

    hdb3_tx_ctrl #(
        .DIV_W      (DIV_W),
        .FLUSH_BITS (4),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_div    (cfg_div),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .enc_ce     (enc_ce),
        .enc_data   (enc_data),
        .enc_clr    (enc_clr),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    typedef struct {
        int         kind;
        logic [1:0] sym;
        logic       ur;
        int         gap;   // required cycles since previous enc_ce; 0 = unchecked
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    int  last_ce  = -1000;
    int  ur_seen  = 0;

    task automatic chk1(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_ev(input int kind, input logic [1:0] sym, input logic ur, input int gap);
        ev_t e;
        e.kind = kind;
        e.sym  = sym;
        e.ur   = ur;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap_first, input int gap);
        for (int i = 7; i >= 0; i--) begin
            push_ev(K_SYM, {1'b0, b[i]}, 1'b0, (i == 7) ? gap_first : gap);
        end
    endtask

    task automatic push_zeros(input int n, input logic ur, input int gap);
        for (int i = 0; i < n; i++) begin
            push_ev(K_SYM, SYM_ZERO, ur, gap);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_err++;
                $display("FAIL event_order: got kind %0d at cycle %0d, required kind %0d", kind, cyc, e.kind);
            end else if (kind == K_SYM) begin
                n_checks++;
                if (enc_data !== e.sym || underrun !== e.ur) begin
                    n_err++;
                    $display("FAIL symbol at cycle %0d: got data=%b underrun=%b, required data=%b underrun=%b",
                             cyc, enc_data, underrun, e.sym, e.ur);
                end
                if (e.gap != 0) begin
                    n_checks++;
                    if (cyc - last_ce != e.gap) begin
                        n_err++;
                        $display("FAIL bit_spacing at cycle %0d: got %0d, required %0d", cyc, cyc - last_ce, e.gap);
                    end
                end
                n_checks++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_during_bit at cycle %0d: got %b, required 1", cyc, busy);
                end
            end else if (kind == K_DONE) begin
                n_checks++;
                if (cyc - last_ce != 1) begin
                    n_err++;
                    $display("FAIL done_latency at cycle %0d: got %0d, required 1", cyc, cyc - last_ce);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_at_clear at cycle %0d: got %b, required 1", cyc, busy);
                end
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (enc_clr) pop_check(K_CLR);
            if (enc_ce) begin
                pop_check(K_SYM);
                last_ce = cyc;
                if (underrun) ur_seen++;
            end else begin
                n_checks++;
                if (enc_data !== SYM_ZERO || underrun !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_outputs at cycle %0d: got data=%b underrun=%b, required 00/0",
                             cyc, enc_data, underrun);
                end
            end
            if (frame_done) pop_check(K_DONE);
        end
    end

    // Caller must be just after a rising edge. Returns the number of
    // falling edges on which s_ready was low before the byte was taken.
    task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
        int n;
        n       = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                break;
            end
            n++;
            if (n > 5000) begin
                n_checks++;
                n_err++;
                $display("FAIL handshake_timeout: s_ready=%b, required 1", s_ready);
                s_valid = 1'b0;
                break;
            end
        end
        waited = n;
    endtask

    task automatic wait_ce(input int k);
        int c;
        int n;
        c = 0;
        n = 0;
        while (c < k && n < 5000) begin
            @(negedge clk);
            n++;
            if (enc_ce) c++;
        end
        if (c < k) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_ce_timeout: got %0d pulses, required %0d", c, k);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_int("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        cfg_div = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_enc_ce", enc_ce, 1'b0);
        chk1("rst_enc_clr", enc_clr, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);

        // 1: single byte 0xA5, period 4
        cfg_div = 16'd3;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'hA5, 0, 4);
        push_zeros(4, 1'b0, 4);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'hA5, 1'b1, w);
        drain();

        // 2: back-to-back 0xFF, 0x00 at one bit per cycle
        cfg_div = 16'd0;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'hFF, 0, 1);
        push_byte(8'h00, 1, 1);
        push_zeros(4, 1'b0, 1);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'hFF, 1'b0, w);
        send_byte(8'h00, 1'b1, w);
        @(negedge clk);
        chk1("s_ready_nxt_full", s_ready, 1'b0);
        drain();

        // 3: late second byte. The 8th enc_ce is visible one cycle after the
        // internal bit-7 tick, so the byte is driven 5 cycles after that tick;
        // ticks in those 5 cycles carry fill bits.
        cfg_div = 16'd0;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'h80, 0, 1);
        push_zeros(5, 1'b1, 1);
        push_byte(8'h01, 1, 1);
        push_zeros(4, 1'b0, 1);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'h80, 1'b0, w);
        wait_ce(8);
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h01, 1'b1, w);
        drain();

        // 4: second byte offered exactly on the bit-7 tick (bypass)
        cfg_div = 16'd2;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'h3C, 0, 3);
        push_byte(8'hC3, 3, 3);
        push_zeros(4, 1'b0, 3);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'h3C, 1'b0, w);
        wait_ce(7);
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'hC3, 1'b1, w);
        chk_int("bypass_ready_wait", w, 0);
        drain();

        // 5: reset pulse during bit 3, then a fresh frame
        cfg_div = 16'd3;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_ev(K_SYM, SYM_ZERO, 1'b0, 0);
        push_ev(K_SYM, SYM_ONE, 1'b0, 4);
        push_ev(K_SYM, SYM_ZERO, 1'b0, 4);
        @(posedge clk); #1;
        send_byte(8'h5A, 1'b1, w);
        wait_ce(3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("abort_s_ready", s_ready, 1'b1);
        chk1("abort_enc_ce", enc_ce, 1'b0);
        chk1("abort_enc_data0", enc_data[0], 1'b0);
        chk1("abort_enc_clr", enc_clr, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_frame_done", frame_done, 1'b0);
        chk1("abort_underrun", underrun, 1'b0);
        chk_int("abort_events_left", exp_q.size(), 0);
        repeat (12) @(negedge clk);
        cfg_div = 16'd1;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'h0F, 0, 2);
        push_zeros(4, 1'b0, 2);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'h0F, 1'b1, w);
        drain();

        // 6: cfg_div change mid-frame is ignored until the next frame
        cfg_div = 16'd3;
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'h96, 0, 4);
        push_byte(8'h69, 4, 4);
        push_zeros(4, 1'b0, 4);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'h96, 1'b0, w);
        send_byte(8'h69, 1'b1, w);
        wait_ce(3);
        cfg_div = 16'd7;
        drain();
        push_ev(K_CLR, SYM_ZERO, 1'b0, 0);
        push_byte(8'h33, 0, 8);
        push_zeros(4, 1'b0, 8);
        push_ev(K_DONE, SYM_ZERO, 1'b0, 0);
        @(posedge clk); #1;
        send_byte(8'h33, 1'b1, w);
        drain();

        chk_int("total_underrun_pulses", ur_seen, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
